// File: rtl/alu_seq.sv
// Clocked ALU with start/busy/done handshake, registered status flags and
// iterative shift-add multiply / restoring divide sharing one hi:lo register pair.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             zflag,
   output logic             nflag,
   output logic             cflag,
   output logic             vflag,
   output logic             hflag,
   output logic             sflag,
   output logic             busy,
   output logic             done
);
   localparam int H  = WIDTH / 2;
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] WV = WIDTH'(WIDTH);

   localparam logic [7:0] OP_LD  = 8'h01, OP_ADD = 8'h03, OP_SUB = 8'h04,
                          OP_AND = 8'h05, OP_OR  = 8'h06, OP_XOR = 8'h07,
                          OP_NOT = 8'h08, OP_SL  = 8'h09, OP_SR  = 8'h0A,
                          OP_MUL = 8'h0B, OP_DIV = 8'h0C, OP_MOD = 8'h0D;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   state_t state;

   logic [WIDTH-1:0] opa, hi, lo;
   logic [CW-1:0]    cnt;
   logic             is_mod;

   // single-cycle result path
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff, r;
   logic             rc, rv, rh, wr_all, wr_ld, mul_go, div_go;

   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = a - b;
      r      = out;
      rc     = 1'b0;
      rv     = 1'b0;
      rh     = 1'b0;
      wr_all = 1'b0;
      wr_ld  = 1'b0;
      mul_go = 1'b0;
      div_go = 1'b0;
      case (op)
         OP_LD:  begin r = a; wr_ld = 1'b1; end
         OP_ADD: begin
            r      = sum[WIDTH-1:0];
            rc     = sum[WIDTH];
            rv     = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            // carry into bit H recovered from the full-width sum
            rh     = sum[H] ^ a[H] ^ b[H];
            wr_all = 1'b1;
         end
         OP_SUB: begin
            r      = diff;
            rc     = a < b;
            rv     = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            rh     = a[H-1:0] < b[H-1:0];
            wr_all = 1'b1;
         end
         OP_AND: begin r = a & b; wr_all = 1'b1; end
         OP_OR:  begin r = a | b; wr_all = 1'b1; end
         OP_XOR: begin r = a ^ b; wr_all = 1'b1; end
         OP_NOT: begin r = ~a;    wr_all = 1'b1; end
         OP_SL: begin
            r      = a << b;
            rc     = (b != '0) && (b <= WV) && a[CW'(WV - b)];
            wr_all = 1'b1;
         end
         OP_SR: begin
            r      = a >> b;
            rc     = (b != '0) && (b <= WV) && a[CW'(b - 1'b1)];
            wr_all = 1'b1;
         end
         OP_MUL: mul_go = 1'b1;
         OP_DIV, OP_MOD: begin
            if (b == '0) begin
               r      = (op == OP_DIV) ? '1 : a;
               rc     = 1'b1;
               wr_all = 1'b1;
            end else begin
               div_go = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // one iteration of each engine; hi:lo is product (MUL) or remainder:quotient (DIV)
   logic [WIDTH:0]   mul_s, div_r, div_t;
   logic [WIDTH-1:0] rem_n, quo_n;
   logic             div_ge;

   always_comb begin
      mul_s  = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
      div_r  = {hi, lo[WIDTH-1]};
      div_t  = div_r - {1'b0, opa};
      div_ge = ~div_t[WIDTH];
      rem_n  = div_ge ? div_t[WIDTH-1:0] : div_r[WIDTH-1:0];
      quo_n  = {lo[WIDTH-2:0], div_ge};
   end

   assign sflag = nflag ^ vflag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         out    <= '0;
         {zflag, nflag, cflag, vflag, hflag} <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         opa    <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         is_mod <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               cnt <= '0;
               if (mul_go) begin
                  opa   <= a;
                  hi    <= '0;
                  lo    <= b;
                  busy  <= 1'b1;
                  state <= MUL;
               end else if (div_go) begin
                  opa    <= b;
                  hi     <= '0;
                  lo     <= a;
                  is_mod <= (op == OP_MOD);
                  busy   <= 1'b1;
                  state  <= DIV;
               end else begin
                  done <= 1'b1;
                  if (wr_all) begin
                     out   <= r;
                     zflag <= (r == '0);
                     nflag <= r[WIDTH-1];
                     cflag <= rc;
                     vflag <= rv;
                     hflag <= rh;
                  end else if (wr_ld) begin
                     out <= r;
                  end
               end
            end
            MUL: begin
               hi  <= mul_s[WIDTH:1];
               lo  <= {mul_s[0], lo[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  out   <= {mul_s[0], lo[WIDTH-1:1]};
                  zflag <= ({mul_s[0], lo[WIDTH-1:1]} == '0);
                  nflag <= mul_s[0];
                  cflag <= (mul_s[WIDTH:1] != '0);
                  vflag <= 1'b0;
                  hflag <= 1'b0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            DIV: begin
               hi  <= rem_n;
               lo  <= quo_n;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  out   <= is_mod ? rem_n : quo_n;
                  zflag <= ((is_mod ? rem_n : quo_n) == '0);
                  nflag <= is_mod ? rem_n[WIDTH-1] : quo_n[WIDTH-1];
                  cflag <= 1'b0;
                  vflag <= 1'b0;
                  hflag <= 1'b0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a reference model predicts each result at issue,
// a negedge monitor pops and compares whenever done pulses.
module tb_alu_seq;
   localparam int W = 32;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [7:0]    op = '0;
   logic [W-1:0]  a = '0, b = '0, out;
   logic          zflag, nflag, cflag, vflag, hflag, sflag, busy, done;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .out(out), .zflag(zflag), .nflag(nflag), .cflag(cflag), .vflag(vflag),
      .hflag(hflag), .sflag(sflag), .busy(busy), .done(done)
   );

   typedef struct {
      string       tag;
      logic [31:0] o;
      logic        z, n, c, v, h;
      int          cyc;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   cyc = 0, n_chk = 0, n_fail = 0, ndone = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t predict(input string tag, input logic [7:0] o,
                                    input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [63:0] w;
      longint      s;
      bit          upd;
      e = m; e.tag = tag; e.cyc = 0; upd = 1;
      case (o)
         8'h01: begin e.o = x; upd = 0; end
         8'h03: begin
            w = {32'b0, x} + {32'b0, y}; e.o = w[31:0]; e.c = w[32];
            s = longint'($signed(x)) + longint'($signed(y));
            e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            e.h = (int'(x[15:0]) + int'(y[15:0])) > 65535;
         end
         8'h04: begin
            e.o = x - y; e.c = x < y;
            s = longint'($signed(x)) - longint'($signed(y));
            e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            e.h = x[15:0] < y[15:0];
         end
         8'h05: begin e.o = x & y; {e.c, e.v, e.h} = '0; end
         8'h06: begin e.o = x | y; {e.c, e.v, e.h} = '0; end
         8'h07: begin e.o = x ^ y; {e.c, e.v, e.h} = '0; end
         8'h08: begin e.o = ~x;    {e.c, e.v, e.h} = '0; end
         8'h09: begin w = {32'b0, x} << y; e.o = w[31:0];  e.c = w[32]; {e.v, e.h} = '0; end
         8'h0A: begin w = {x, 32'b0} >> y; e.o = w[63:32]; e.c = w[31]; {e.v, e.h} = '0; end
         8'h0B: begin
            w = 64'(x) * 64'(y); e.o = w[31:0]; e.c = |w[63:32]; {e.v, e.h} = '0; e.cyc = 32;
         end
         8'h0C, 8'h0D: begin
            {e.v, e.h} = '0;
            if (y == 0) begin e.o = (o == 8'h0C) ? 32'hFFFF_FFFF : x; e.c = 1; end
            else begin e.o = (o == 8'h0C) ? x / y : x % y; e.c = 0; e.cyc = 32; end
         end
         default: upd = 0;
      endcase
      if (upd) begin e.z = (e.o == 0); e.n = e.o[31]; end
      return e;
   endfunction

   task automatic issue(input string tag, input logic [7:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      e = predict(tag, o, x, y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      e.cyc = e.cyc + cyc;
      q.push_back(e);
      m = e;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         chk("timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            ndone++;
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else begin
               e = q.pop_front();
               chk({e.tag, ".out"}, out, e.o);
               chk({e.tag, ".flags"}, {zflag, nflag, cflag, vflag, hflag}, {e.z, e.n, e.c, e.v, e.h});
               chk({e.tag, ".s"}, sflag, e.n ^ e.v);
               chk({e.tag, ".lat"}, 64'(cyc), 64'(e.cyc));
               chk({e.tag, ".busy"}, busy, 0);
            end
         end
      end
   end

   initial begin
      int          d0;
      logic [7:0]  ops [14];
      logic [7:0]  o;
      logic [31:0] x, y;
      ops = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hFF, 8'h42};
      m = '{tag: "", o: 0, z: 0, n: 0, c: 0, v: 0, h: 0, cyc: 0};
      #1;
      chk("rst.state", {out, zflag, nflag, cflag, vflag, hflag, sflag, busy, done}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue("add_ovf", 8'h03, 32'h7FFF_FFFF, 32'h1); wait_idle();
      chk("add_ovf.direct", {out, nflag, vflag, cflag, sflag}, {32'h8000_0000, 4'b1100});
      issue("add_wrap", 8'h03, 32'hFFFF_FFFF, 32'h1); wait_idle();
      chk("add_wrap.direct", {out, zflag, cflag, hflag}, {32'h0, 3'b111});
      issue("sub", 8'h04, 32'd3, 32'd5); wait_idle();
      chk("sub.direct", {out, cflag, nflag, vflag, hflag, sflag}, {32'hFFFF_FFFE, 5'b11011});

      // back-to-back single-cycle ops with start held high
      issue("sl1", 8'h09, 32'h8000_0001, 32'd1);
      issue("sr40", 8'h0A, 32'hFFFF_FFFF, 32'd40);
      issue("ld", 8'h01, 32'h1234, 32'h0);
      wait_idle();
      chk("ld.direct", {out, zflag, cflag}, {32'h1234, 2'b10});
      issue("sl32", 8'h09, 32'h0000_0001, 32'd32);
      issue("sr32", 8'h0A, 32'h8000_0000, 32'd32);
      issue("sl0", 8'h09, 32'hA5A5_0001, 32'd0);
      issue("sr31", 8'h0A, 32'h8000_0000, 32'd31);
      issue("sl33", 8'h09, 32'hFFFF_FFFF, 32'd33);
      wait_idle();

      issue("mul", 8'h0B, 32'h0001_0000, 32'h0001_0000);
      repeat (10) @(negedge clk);
      chk("mul.busy_mid", {busy, out}, {1'b1, 32'h0});
      start = 1'b1; op = 8'h03; a = 32'd1; b = 32'd2;
      @(posedge clk); #1; start = 1'b0;
      wait_idle();
      chk("mul.direct", {out, cflag, zflag}, {32'h0, 2'b11});

      issue("divu", 8'h0C, 32'd100, 32'd7); wait_idle();
      chk("divu.direct", out, 32'd14);
      issue("modu", 8'h0D, 32'd100, 32'd7); wait_idle();
      chk("modu.direct", out, 32'd2);
      issue("div0", 8'h0C, 32'd5, 32'd0);
      issue("mod0", 8'h0D, 32'd9, 32'd0);
      wait_idle();
      issue("unk", 8'hFF, 32'd77, 32'd88); wait_idle();
      chk("unk.direct", {out, cflag}, {32'd9, 1'b1});

      for (int i = 0; i < 40; i++) begin
         o = ops[$urandom_range(0, 13)];
         x = $urandom();
         y = $urandom();
         if (o == 8'h09 || o == 8'h0A) y = $urandom_range(0, 40);
         if ((o == 8'h0C || o == 8'h0D) && ($urandom_range(0, 3) == 0)) y = 0;
         if (o == 8'h0C && $urandom_range(0, 1) == 1) y = $urandom_range(1, 1000);
         issue($sformatf("rnd%0d_op%0h", i, o), o, x, y);
         if (o == 8'h0B || o == 8'h0C || o == 8'h0D) wait_idle();
      end
      wait_idle();

      // reset in the middle of a multiply aborts it with no done
      issue("mul_abort", 8'h0B, 32'd123, 32'd456);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid.state", {out, zflag, nflag, cflag, vflag, hflag, sflag, busy, done}, 0);
      q.delete();
      m = '{tag: "", o: 0, z: 0, n: 0, c: 0, v: 0, h: 0, cyc: 0};
      d0 = ndone;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("rst_mid.no_done", 64'(ndone - d0), 0);
      chk("rst_mid.out", {out, busy}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the single-cycle CPU ALU. It adds:
- a configurable datapath width;
- a start/busy/done handshake;
- iterative unsigned multiply, divide and modulo;
- registered status flags with fully defined update rules.

It sits between the decode/register-read stage and the status register. The sequencer raises `start` and waits for `done` before consuming `out` and the flags.

## Interface
- `WIDTH`, 32, datapath width; even, ≥ 8. `H = WIDTH/2` is the half-carry boundary.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; honoured only when `busy` = 0.
- `op`  in  8  opcode, sampled on an accepted `start`.
- `a`  in  WIDTH  operand A, sampled on an accepted `start`.
- `b`  in  WIDTH  operand B, sampled on an accepted `start`.
- `out`  out  WIDTH  result register.
- `zflag`  out  1  zero.
- `nflag`  out  1  negative (`out[WIDTH-1]`).
- `cflag`  out  1  carry/borrow.
- `vflag`  out  1  signed overflow.
- `hflag`  out  1  half carry/borrow at bit H-1.
- `sflag`  out  1  combinational `nflag ^ vflag`.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse: `out` and flags have just been updated.

## Operation
States: IDLE, MUL, DIV.

Opcodes and results:
- 01 LD: `out = a`; flags unchanged.
- 03 ADD: `out = a + b`.
  - `c` = carry out of bit WIDTH-1.
  - `v` = both operand signs equal and `out` sign differs.
  - `h` = carry out of bit H-1.
- 04 SUB: `out = a - b`.
  - `c` = borrow (a < b, unsigned).
  - `v` = operand signs differ and `out` sign differs from `a`.
  - `h` = `a[H-1:0] < b[H-1:0]`.
- 05 AND, 06 OR, 07 XOR: bitwise; `c = v = h = 0`.
- 08 NOT: `out = ~a`; `c = v = h = 0`.
- 09 SL, 0A SR (logical), shift amount `b` (full width):
  - `b` = 0: `out = a`, `c` = 0.
  - 1 ≤ `b` < WIDTH: `c` = last bit shifted out.
  - `b` ≥ WIDTH: `out` = 0; `c` = bit `a[0]` (SL) / `a[WIDTH-1]` (SR) only when `b` == WIDTH, else 0.
  - `v = h = 0`.
- 0B MUL: `out` = low WIDTH bits of unsigned `a*b`; `c` = 1 if the high WIDTH bits ≠ 0; `v = h = 0`.
  - Shift-add, one partial product per cycle.
- 0C DIVU: `out = a / b`, unsigned restoring division, one quotient bit per cycle.
- 0D MODU: `out = a % b`, same engine as DIVU.
  - DIVU/MODU flags: `c = v = h = 0`.
- Divide by zero (0C/0D with `b` = 0): bypasses DIV state.
  - `out` = all-ones (0C) or `a` (0D).
  - `c` = 1, `v = h = 0`.
- All opcodes except 01 and unknown: `z = (out == 0)`, `n = out[WIDTH-1]`.
- Unknown opcode: `out` and all flags unchanged; `done` still pulses.

Flags change only on the edge that asserts `done`; they hold otherwise.

## Timing
- Reset (async assert, sync release): `out` = 0, z/n/c/v/h = 0, `sflag` = 0, `busy` = 0, `done` = 0, state IDLE.
  - Reset mid-operation aborts the operation with no `done`.
- Accepted start = rising edge with `start` = 1 and state IDLE. Call this edge k.
- Single-cycle ops (01, 03–0A, unknown, divide by zero):
  - `out` and flags update at edge k.
  - `done` = 1 for the cycle after edge k.
  - `busy` stays 0.
- MUL/DIVU/MODU (b ≠ 0):
  - At edge k, operands are latched into internal registers; state becomes MUL or DIV; `busy` = 1.
  - The engine iterates WIDTH cycles.
  - At edge k+WIDTH: `out` and flags update, `done` = 1, `busy` = 0, state IDLE.
  - Latency is WIDTH cycles; `out` holds its previous value until then.
- `start` while `busy` = 1: ignored. Operand changes during busy have no effect.
- `start` held high continuously: a new operation is accepted at every IDLE edge, including the edge right after a single-cycle op. Back-to-back throughput is 1 per cycle for single-cycle ops.
- `done` never asserts without an accepted start.

## Test plan
- Reset: assert `rst_n` = 0 mid-MUL → `busy`, `done`, `out` and flags all go 0 immediately. After release, no `done` appears.
- ADD, WIDTH = 32:
  - `7FFF_FFFF + 1` → `out` = `8000_0000`, n = 1, v = 1, c = 0, s = 0.
  - `FFFF_FFFF + 1` → `out` = 0, z = 1, c = 1, h = 1.
  - `done` appears 1 cycle after start.
- SUB: `3 - 5` → `out` = `FFFF_FFFE`, c = 1, n = 1, v = 0, h = 1, s = 1.
- Shifts:
  - SL `a = 8000_0001`, `b` = 1 → `out` = 2, c = 1.
  - SR `b` = 40 → `out` = 0, z = 1, c = 0.
  - LD after these → flags unchanged.
- MUL/DIV:
  - `0001_0000 * 0001_0000` → `out` = 0, c = 1, z = 1; `done` exactly 32 cycles after start.
  - DIVU `100/7` → 14; MODU `100 % 7` → 2.
  - A `start` pulse during busy is ignored.
- Divide by zero and unknown opcode:
  - DIVU `b` = 0 → `out` = `FFFF_FFFF`, c = 1; MODU `a` = 9, `b` = 0 → `out` = 9, c = 1. Both have 1-cycle latency.
  - Opcode `FF` → `out` and flags unchanged, `done` pulses.
